// File: rtl/cache_pkg.sv
// Shared definitions for the cache refill controller: FSM state encoding,
// default cache geometry and the main-memory line-address width helper.
package cache_pkg;

  localparam int DEFAULT_AINDEX_WIDTH   = 8;
  localparam int DEFAULT_CH_NUM_WIDTH   = 2;
  localparam int DEFAULT_CASH_STR_WIDTH = 64;
  localparam int DEFAULT_TAG_WIDTH      = 22;

  // A main-memory line address is the concatenation {tag, index}.
  function automatic int lineAddrWidth(input int tagWidth, input int indexWidth);
    return tagWidth + indexWidth;
  endfunction

  typedef enum logic [2:0] {
    IDLE,
    WB_READ,
    WB_REQ,
    FILL_REQ,
    FILL_WRITE,
    DONE
  } refill_state_e;

endpackage

// File: rtl/cache_refill_ctrl.sv
// Miss refill controller: optional dirty-victim write-back, line fetch over req/ack,
// then a single-cycle fill of the data memory. Write-back exists only with CACHE_WRITEBACK_EN.
module cache_refill_ctrl
  import cache_pkg::*;
#(
  parameter int AINDEX_WIDTH   = DEFAULT_AINDEX_WIDTH,
  parameter int CH_NUM_WIDTH   = DEFAULT_CH_NUM_WIDTH,
  parameter int CASH_STR_WIDTH = DEFAULT_CASH_STR_WIDTH,
  parameter int TAG_WIDTH      = DEFAULT_TAG_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      miss_valid,
  output logic                      miss_ready,
  input  logic [AINDEX_WIDTH-1:0]   miss_index,
  input  logic [TAG_WIDTH-1:0]      miss_tag,
  input  logic [CH_NUM_WIDTH-1:0]   victim_channel,
  input  logic                      victim_dirty,
  input  logic [TAG_WIDTH-1:0]      victim_tag,
  output logic                      done,
  output logic [AINDEX_WIDTH-1:0]   dm_index,
  output logic [CH_NUM_WIDTH-1:0]   dm_channel,
  output logic                      dm_write,
  output logic [CASH_STR_WIDTH-1:0] dm_wdata,
  input  logic [CASH_STR_WIDTH-1:0] dm_rdata,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [lineAddrWidth(TAG_WIDTH, AINDEX_WIDTH)-1:0] mem_addr,
  output logic [CASH_STR_WIDTH-1:0] mem_wdata,
  input  logic [CASH_STR_WIDTH-1:0] mem_rdata,
  input  logic                      mem_ack
);

  localparam int LINE_ADDR_WIDTH = lineAddrWidth(TAG_WIDTH, AINDEX_WIDTH);

  refill_state_e r_state;
  refill_state_e w_nextState;

  logic [AINDEX_WIDTH-1:0]   r_index;
  logic [CH_NUM_WIDTH-1:0]   r_channel;
  logic [TAG_WIDTH-1:0]      r_missTag;
  logic [CASH_STR_WIDTH-1:0] r_lineBuf;
  logic                      w_accept;

  assign w_accept = (r_state == IDLE) && miss_valid;

`ifdef CACHE_WRITEBACK_EN
  logic [TAG_WIDTH-1:0] r_victimTag;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_victimTag <= '0;
    end else if (w_accept) begin
      r_victimTag <= victim_tag;
    end
  end
`else
  // Write-through build: victim information and array read data have no consumer.
  logic w_unusedInputs;
  assign w_unusedInputs = ^{victim_dirty, victim_tag, dm_rdata};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Every output below depends on the state register and latched data only.
  always_comb begin
    w_nextState = r_state;
    miss_ready  = 1'b0;
    done        = 1'b0;
    dm_write    = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = {LINE_ADDR_WIDTH{1'b0}};
    mem_wdata   = {CASH_STR_WIDTH{1'b0}};
    case (r_state)
      IDLE: begin
        miss_ready = 1'b1;
        if (miss_valid) begin
`ifdef CACHE_WRITEBACK_EN
          w_nextState = victim_dirty ? WB_READ : FILL_REQ;
`else
          w_nextState = FILL_REQ;
`endif
        end
      end
`ifdef CACHE_WRITEBACK_EN
      WB_READ: begin
        w_nextState = WB_REQ;
      end
      WB_REQ: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {r_victimTag, r_index};
        mem_wdata = r_lineBuf;
        if (mem_ack) begin
          w_nextState = FILL_REQ;
        end
      end
`endif
      FILL_REQ: begin
        mem_req  = 1'b1;
        mem_addr = {r_missTag, r_index};
        if (mem_ack) begin
          w_nextState = FILL_WRITE;
        end
      end
      FILL_WRITE: begin
        dm_write    = 1'b1;
        w_nextState = DONE;
      end
      DONE: begin
        done        = 1'b1;
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // The line buffer carries the victim line out and the fetched line back in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_index   <= '0;
      r_channel <= '0;
      r_missTag <= '0;
      r_lineBuf <= '0;
    end else begin
      if (w_accept) begin
        r_index   <= miss_index;
        r_channel <= victim_channel;
        r_missTag <= miss_tag;
      end
`ifdef CACHE_WRITEBACK_EN
      if (r_state == WB_READ) begin
        r_lineBuf <= dm_rdata;
      end
`endif
      if ((r_state == FILL_REQ) && mem_ack) begin
        r_lineBuf <= mem_rdata;
      end
    end
  end

  assign dm_index   = r_index;
  assign dm_channel = r_channel;
  assign dm_wdata   = r_lineBuf;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Randomized self-checking bench for cache_refill_ctrl against a cycle-timeline
// reference model with behavioural data-array and main-memory models.
module tb_cache_refill_ctrl;

  localparam int IW = 8;
  localparam int CW = 2;
  localparam int DW = 64;
  localparam int TW = 22;
  localparam int AW = TW + IW;
`ifdef CACHE_WRITEBACK_EN
  localparam bit WB_EN = 1'b1;
`else
  localparam bit WB_EN = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic          miss_valid;
  logic          miss_ready;
  logic [IW-1:0] miss_index;
  logic [TW-1:0] miss_tag;
  logic [CW-1:0] victim_channel;
  logic          victim_dirty;
  logic [TW-1:0] victim_tag;
  logic          done;
  logic [IW-1:0] dm_index;
  logic [CW-1:0] dm_channel;
  logic          dm_write;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] dm_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;

  logic [DW-1:0] dataMem [0:255][0:3];
  logic [DW-1:0] mainMem [bit [AW-1:0]];

  int checkCount;
  int errorCount;

  cache_refill_ctrl dut (
    .clk(clk), .reset(reset),
    .miss_valid(miss_valid), .miss_ready(miss_ready),
    .miss_index(miss_index), .miss_tag(miss_tag),
    .victim_channel(victim_channel), .victim_dirty(victim_dirty), .victim_tag(victim_tag),
    .done(done),
    .dm_index(dm_index), .dm_channel(dm_channel), .dm_write(dm_write),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  // The data array answers reads combinationally from whatever index/channel is driven.
  assign dm_rdata = dataMem[dm_index][dm_channel];

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [DW-1:0] randomLine();
    return {$urandom(), $urandom()};
  endfunction

  task automatic scrambleMissInputs();
    miss_index     = IW'($urandom());
    miss_tag       = TW'($urandom());
    victim_channel = CW'($urandom());
    victim_dirty   = 1'($urandom());
    victim_tag     = TW'($urandom());
  endtask

  // One complete miss: the expected cycle of every event is worked out up front from
  // the handshake rules, and the bench plays main memory from that same timeline.
  task automatic applyStimulus(input logic [IW-1:0] idx, input logic [TW-1:0] tag,
                               input logic [CW-1:0] ch, input logic dirty,
                               input logic [TW-1:0] vtag, input int wbDelay,
                               input int fillDelay, input bit holdValid);
    logic [DW-1:0] victimData;
    logic [DW-1:0] fillData;
    logic [AW-1:0] wbAddr;
    logic [AW-1:0] fillAddr;
    logic [AW-1:0] expAddr;
    bit doWb;
    bit expReq;
    bit expWe;
    int wbStart;
    int wbEnd;
    int fillStart;
    int fillEnd;
    int expDone;

    doWb       = WB_EN && dirty;
    victimData = dataMem[idx][ch];
    wbAddr     = {vtag, idx};
    fillAddr   = {tag, idx};
    if (doWb) mainMem[wbAddr] = victimData;
    if (!mainMem.exists(fillAddr)) mainMem[fillAddr] = randomLine();
    fillData  = mainMem[fillAddr];
    wbStart   = 2;
    wbEnd     = wbStart + wbDelay;
    fillStart = doWb ? wbEnd + 1 : 1;
    fillEnd   = fillStart + fillDelay;
    expDone   = fillEnd + 2;

    @(negedge clk);
    checkOutput("idle_ready", miss_ready, 1'b1);
    checkOutput("idle_req", mem_req, 1'b0);
    miss_valid     = 1'b1;
    miss_index     = idx;
    miss_tag       = tag;
    victim_channel = ch;
    victim_dirty   = dirty;
    victim_tag     = vtag;
    mem_ack        = 1'b0;

    for (int k = 1; k <= expDone + 1; k++) begin
      @(negedge clk);
      expWe   = doWb && (k >= wbStart) && (k <= wbEnd);
      expReq  = expWe || ((k >= fillStart) && (k <= fillEnd));
      expAddr = expWe ? wbAddr : fillAddr;
      checkOutput("miss_ready", miss_ready, k == expDone + 1);
      checkOutput("done", done, k == expDone);
      checkOutput("dm_write", dm_write, k == expDone - 1);
      checkOutput("dm_index", dm_index, idx);
      checkOutput("dm_channel", dm_channel, ch);
      checkOutput("mem_req", mem_req, expReq);
      if (k == expDone - 1) checkOutput("dm_wdata", dm_wdata, fillData);
      if (expReq) begin
        checkOutput("mem_addr", mem_addr, expAddr);
        checkOutput("mem_we", mem_we, expWe);
      end
      if (expWe) checkOutput("mem_wdata", mem_wdata, victimData);
      if (!WB_EN) checkOutput("mem_we_tied", mem_we, 1'b0);

      miss_valid = holdValid && (k < expDone);
      scrambleMissInputs();
      mem_rdata = randomLine();
      if ((doWb && k == wbEnd) || k == fillEnd) begin
        mem_ack = 1'b1;
        if (k == fillEnd) mem_rdata = fillData;
      end else begin
        mem_ack = expReq ? 1'b0 : ($urandom_range(0, 3) == 0);
      end
    end
    miss_valid = 1'b0;
    mem_ack    = 1'b0;
    dataMem[idx][ch] = fillData;
  endtask

  // Reset lands while a fill request is outstanding; everything must drop at once.
  task automatic applyResetAbort();
    @(negedge clk);
    miss_valid     = 1'b1;
    miss_index     = 8'h5A;
    miss_tag       = 22'h0ABCD;
    victim_channel = 2'd3;
    victim_dirty   = 1'b0;
    victim_tag     = 22'h0;
    mem_ack        = 1'b0;
    @(negedge clk);
    miss_valid = 1'b0;
    checkOutput("abort_req_before", mem_req, 1'b1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("abort_req_drop", mem_req, 1'b0);
    checkOutput("abort_write", dm_write, 1'b0);
    checkOutput("abort_ready", miss_ready, 1'b1);
    checkOutput("abort_done", done, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      mem_ack   = 1'($urandom());
      mem_rdata = randomLine();
      @(negedge clk);
      checkOutput("post_abort_done", done, 1'b0);
      checkOutput("post_abort_write", dm_write, 1'b0);
      checkOutput("post_abort_req", mem_req, 1'b0);
      checkOutput("post_abort_ready", miss_ready, 1'b1);
    end
    mem_ack = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    clk            = 1'b0;
    reset          = 1'b1;
    miss_valid     = 1'b0;
    miss_index     = '0;
    miss_tag       = '0;
    victim_channel = '0;
    victim_dirty   = 1'b0;
    victim_tag     = '0;
    mem_rdata      = '0;
    mem_ack        = 1'b0;
    checkCount     = 0;
    errorCount     = 0;
    for (int i = 0; i < 256; i++)
      for (int j = 0; j < 4; j++)
        dataMem[i][j] = randomLine();

    repeat (2) @(negedge clk);
    checkOutput("rst_miss_ready", miss_ready, 1'b1);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_dm_write", dm_write, 1'b0);
    checkOutput("rst_dm_index", dm_index, 0);
    checkOutput("rst_dm_channel", dm_channel, 0);
    checkOutput("rst_dm_wdata", dm_wdata, 0);
    checkOutput("rst_mem_req", mem_req, 1'b0);
    checkOutput("rst_mem_we", mem_we, 1'b0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_mem_wdata", mem_wdata, 0);
    reset = 1'b0;

    mainMem[{22'h3ABCD, 8'h12}] = 64'hDEADBEEF_01234567;
    applyStimulus(8'h12, 22'h3ABCD, 2'd2, 1'b0, 22'h0, 0, 0, 1'b0);

    dataMem[8'h40][1] = 64'hA5A5A5A5_A5A5A5A5;
    applyStimulus(8'h40, 22'h2F00F, 2'd1, 1'b1, 22'h1111, 5, 5, 1'b0);

    applyStimulus(8'h77, 22'h01234, 2'd0, 1'b1, 22'h00F0F, 1, 2, 1'b1);
    applyStimulus(8'h78, 22'h01235, 2'd3, 1'b0, 22'h0, 0, 1, 1'b1);

    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      mem_ack   = 1'b1;
      mem_rdata = randomLine();
      @(negedge clk);
      mem_ack = 1'b0;
      checkOutput("spurious_ready", miss_ready, 1'b1);
      checkOutput("spurious_req", mem_req, 1'b0);
      checkOutput("spurious_write", dm_write, 1'b0);
      checkOutput("spurious_done", done, 1'b0);
    end

    applyResetAbort();

    for (int n = 0; n < 40; n++) begin
      applyStimulus(IW'($urandom()), TW'($urandom_range(0, 15)), CW'($urandom()),
                    1'($urandom()), TW'($urandom_range(0, 15)),
                    $urandom_range(0, 4), $urandom_range(0, 4), 1'($urandom()));
    end

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
